id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand selection directly upstream of the 64-bit ALU.
//  Captures decoded operands/controls, decodes the 4-bit ALU opcode, forwards results from EX/MEM and MEM/WB,
//  and drives ALU a/b/ALUop. Also flags load-use hazards back to the hazard/stall logic.
// PARAMETERS
//  XLEN   64  datapath width (ALU operand width)
//  RAW    5   register-address width
// PORTS
//  clk            in   1     clock, all state updates on rising edge
//  reset          in   1     synchronous, active-high
//  stall          in   1     hold all ID/EX registers this cycle
//  flush          in   1     load a bubble into ID/EX this cycle
//  id_valid       in   1     decode slot holds a real instruction
//  id_rs1/id_rs2  in   RAW   source register numbers
//  id_rd          in   RAW   destination register number
//  id_rs1_data    in   XLEN  register-file read data port 1
//  id_rs2_data    in   XLEN  register-file read data port 2
//  id_imm         in   XLEN  sign-extended immediate
//  id_funct3      in   3     instr[14:12]
//  id_funct7b5    in   1     instr[30]
//  id_aluop       in   2     00 load/store, 01 branch, 10 R-type, 11 I-type arith
//  id_alusrc      in   1     1: ALU b = immediate
//  id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch  in 1 each  control bits
//  exmem_regwrite in   1 ; exmem_rd in RAW ; exmem_result in XLEN   EX/MEM forwarding source
//  memwb_regwrite in   1 ; memwb_rd in RAW ; memwb_result in XLEN   MEM/WB forwarding source
//  alu_a, alu_b   out  XLEN  ALU operands (a, b)
//  alu_op         out  4     ALU opcode (ALUop)
//  ex_store_data  out  XLEN  forwarded rs2 value for stores
//  ex_valid, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  registered fields
//  load_use_hazard out 1     combinational stall request to decode
// BEHAVIOUR
//  Register update priority per edge: reset > flush > stall > load.
//  - reset: all registers 0, alu_op register = 4'b0010 (add); ex_valid and all control outputs 0.
//  - flush: ex_valid, regwrite, memread, memwrite, memtoreg, branch <= 0; data/rd fields <= 0; alu_op <= 0010.
//  - stall (no flush): every register holds. flush+stall same cycle -> flush wins.
//  - otherwise: capture all id_* inputs; alu_op decoded at capture time.
//  ALU opcode decode (registered, 1-cycle latency from id_* to alu_op):
//   aluop 00 -> 0010 ; 01 -> 0110 ; 11 -> 0010 (funct ignored)
//   aluop 10: funct3 000 & f7b5=0 -> 0010 ; 000 & f7b5=1 -> 0110 ; 111 -> 0000 ; 110 -> 0001 ; other -> 0010.
//   Note: 1100 (NOR) is never generated by this stage.
//  Forwarding (combinational from registered fields and current-cycle forwarding inputs), per source rsX:
//   1. exmem_regwrite && exmem_rd!=0 && exmem_rd==rsX -> exmem_result
//   2. else memwb_regwrite && memwb_rd!=0 && memwb_rd==rsX -> memwb_result
//   3. else registered rsX_data. Register x0 is never forwarded.
//  alu_a = fwd(rs1). ex_store_data = fwd(rs2). alu_b = alusrc ? imm : fwd(rs2).
//  Forwarding applies regardless of ex_valid (bubble fields are 0, so harmless).
//  load_use_hazard = ex_valid && ex_memread && ex_rd!=0 && id_valid && (ex_rd==id_rs1 || ex_rd==id_rs2).
//   Pure combinational; stage does not stall itself, decode feeds it back via stall/flush.
//  No arithmetic performed here; all widths pass through unmodified (XLEN).
// TESTING
//  1. reset=1 two cycles -> ex_valid=0, all controls 0, alu_op=0010, alu_a=alu_b=0.
//  2. R-type sub: rs1_data=10, rs2_data=3, aluop=10, f3=000, f7b5=1 -> next cycle alu_op=0110, a=10, b=3.
//  3. Forward priority: ex rs1=5, exmem_rd=5/res=0xAA, memwb_rd=5/res=0xBB, both regwrite -> alu_a=0xAA;
//     drop exmem_regwrite -> alu_a=0xBB; set rd=0 on both -> alu_a=registered rs1_data.
//  4. alusrc=1, imm=-4 (0xFFFF_FFFF_FFFF_FFFC), rs2 forwarded 7 -> alu_b=imm, ex_store_data=7.
//  5. stall=1 with new id_* values -> all outputs unchanged; stall=1,flush=1 -> ex_valid=0, regwrite=0, alu_op=0010.
//  6. ex lw rd=8, id rs2=8 id_valid=1 -> load_use_hazard=1; same with ex_rd=0 or id_valid=0 -> 0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with registered ALU-opcode decode, EX/MEM and MEM/WB
// operand forwarding, and a combinational load-use hazard flag for decode.
module id_ex_operand_stage #(
    parameter int XLEN = 64,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic [1:0]      id_aluop,
    input  logic            id_alusrc,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            id_branch,
    input  logic            exmem_regwrite,
    input  logic [RAW-1:0]  exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_regwrite,
    input  logic [RAW-1:0]  memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_valid,
    output logic [RAW-1:0]  ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_branch,
    output logic            load_use_hazard
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic            r_valid;
    logic [RAW-1:0]  r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0] r_rs1_data, r_rs2_data, r_imm;
    logic            r_alusrc, r_regwrite, r_memread, r_memwrite, r_memtoreg, r_branch;
    logic [3:0]      r_alu_op;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_fwd_rs1, w_fwd_rs2;

    always_comb begin
        w_alu_op = OP_ADD;
        case (id_aluop)
            2'b01: w_alu_op = OP_SUB;
            2'b10: begin
                case (id_funct3)
                    3'b000:  w_alu_op = id_funct7b5 ? OP_SUB : OP_ADD;
                    3'b111:  w_alu_op = OP_AND;
                    3'b110:  w_alu_op = OP_OR;
                    default: w_alu_op = OP_ADD;
                endcase
            end
            default: w_alu_op = OP_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid    <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_alu_op   <= OP_ADD;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_alusrc   <= id_alusrc;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_memwrite <= id_memwrite;
            r_memtoreg <= id_memtoreg;
            r_branch   <= id_branch;
            r_alu_op   <= w_alu_op;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; x0 is hardwired zero.
    function automatic logic [XLEN-1:0] fwd(input logic [RAW-1:0] rs, input logic [XLEN-1:0] rdata,
                                            input logic ex_we, input logic [RAW-1:0] ex_rd_n,
                                            input logic [XLEN-1:0] ex_res, input logic wb_we,
                                            input logic [RAW-1:0] wb_rd_n, input logic [XLEN-1:0] wb_res);
        if (ex_we && ex_rd_n != '0 && ex_rd_n == rs)
            return ex_res;
        else if (wb_we && wb_rd_n != '0 && wb_rd_n == rs)
            return wb_res;
        else
            return rdata;
    endfunction

    assign w_fwd_rs1 = fwd(r_rs1, r_rs1_data, exmem_regwrite, exmem_rd, exmem_result,
                           memwb_regwrite, memwb_rd, memwb_result);
    assign w_fwd_rs2 = fwd(r_rs2, r_rs2_data, exmem_regwrite, exmem_rd, exmem_result,
                           memwb_regwrite, memwb_rd, memwb_result);

    assign alu_a         = w_fwd_rs1;
    assign alu_b         = r_alusrc ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign alu_op        = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_rd         = r_rd;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign ex_memtoreg   = r_memtoreg;
    assign ex_branch     = r_branch;

    assign load_use_hazard = r_valid && r_memread && (r_rd != '0) && id_valid &&
                             ((r_rd == id_rs1) || (r_rd == id_rs2));
endmodule
